// File: rtl/aes_req_arbiter.sv
// ============================================================================
// Module  : aes_req_arbiter
// Brief   : Two-requester round-robin front end for an AES core, with key reuse.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module aes_req_arbiter #(
    parameter int KEY_REUSE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req,
    input  logic [1:0]   req_encdec,
    input  logic [1:0]   req_keylen,
    input  logic [255:0] req_key0,
    input  logic [255:0] req_key1,
    input  logic [127:0] req_block0,
    input  logic [127:0] req_block1,
    output logic [1:0]   gnt,
    output logic [1:0]   rsp_valid,
    output logic [127:0] rsp_data,
    output logic         busy,
    output logic         core_init,
    output logic         core_next,
    output logic         core_encdec,
    output logic         core_keylen,
    output logic [255:0] core_key,
    output logic [127:0] core_block,
    input  logic         core_ready,
    input  logic         core_result_valid,
    input  logic [127:0] core_result
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        KBLANK = 3'd2,
        KWAIT  = 3'd3,
        NEXT   = 3'd4,
        RBLANK = 3'd5,
        RWAIT  = 3'd6
    } state_t;

    state_t         state_q, state_d;
    logic           owner_q, owner_d;
    logic           last_owner_q, last_owner_d;
    logic           key_valid_q, key_valid_d;
    logic [255:0]   key_store_q, key_store_d;
    logic           keylen_store_q, keylen_store_d;
    logic [1:0]     gnt_q, gnt_d;
    logic [1:0]     rsp_valid_q, rsp_valid_d;
    logic [127:0]   rsp_data_q, rsp_data_d;
    logic           core_encdec_q, core_encdec_d;
    logic           core_keylen_q, core_keylen_d;
    logic [255:0]   core_key_q, core_key_d;
    logic [127:0]   core_block_q, core_block_d;

    logic           w_win;
    logic [255:0]   w_win_key;
    logic [127:0]   w_win_block;
    logic           w_win_keylen;
    logic           w_win_encdec;
    logic           w_key_hit;

    // On a tie the requester that did not finish the last job wins.
    assign w_win        = (req == 2'b11) ? ~last_owner_q : req[1];
    assign w_win_key    = w_win ? req_key1 : req_key0;
    assign w_win_block  = w_win ? req_block1 : req_block0;
    assign w_win_keylen = req_keylen[w_win];
    assign w_win_encdec = req_encdec[w_win];
    assign w_key_hit    = (KEY_REUSE != 0) && key_valid_q &&
                          (w_win_key == key_store_q) && (w_win_keylen == keylen_store_q);

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_owner_d   = last_owner_q;
        key_valid_d    = key_valid_q;
        key_store_d    = key_store_q;
        keylen_store_d = keylen_store_q;
        rsp_data_d     = rsp_data_q;
        core_encdec_d  = core_encdec_q;
        core_keylen_d  = core_keylen_q;
        core_key_d     = core_key_q;
        core_block_d   = core_block_q;
        gnt_d          = 2'b00;
        rsp_valid_d    = 2'b00;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d       = w_win;
                    gnt_d         = w_win ? 2'b10 : 2'b01;
                    core_key_d    = w_win_key;
                    core_block_d  = w_win_block;
                    core_keylen_d = w_win_keylen;
                    core_encdec_d = w_win_encdec;
                    state_d       = w_key_hit ? NEXT : INIT;
                end
            end
            INIT:   state_d = KBLANK;
            KBLANK: state_d = KWAIT;
            KWAIT: begin
                if (core_ready) begin
                    key_store_d    = core_key_q;
                    keylen_store_d = core_keylen_q;
                    key_valid_d    = 1'b1;
                    state_d        = NEXT;
                end
            end
            NEXT:   state_d = RBLANK;
            RBLANK: state_d = RWAIT;
            RWAIT: begin
                if (core_result_valid) begin
                    rsp_data_d   = core_result;
                    rsp_valid_d  = owner_q ? 2'b10 : 2'b01;
                    last_owner_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            owner_q        <= 1'b0;
            last_owner_q   <= 1'b1;
            key_valid_q    <= 1'b0;
            key_store_q    <= '0;
            keylen_store_q <= 1'b0;
            gnt_q          <= 2'b00;
            rsp_valid_q    <= 2'b00;
            rsp_data_q     <= '0;
            core_encdec_q  <= 1'b0;
            core_keylen_q  <= 1'b0;
            core_key_q     <= '0;
            core_block_q   <= '0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_owner_q   <= last_owner_d;
            key_valid_q    <= key_valid_d;
            key_store_q    <= key_store_d;
            keylen_store_q <= keylen_store_d;
            gnt_q          <= gnt_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            core_encdec_q  <= core_encdec_d;
            core_keylen_q  <= core_keylen_d;
            core_key_q     <= core_key_d;
            core_block_q   <= core_block_d;
        end
    end

    assign gnt         = gnt_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign busy        = (state_q != IDLE);
    assign core_init   = (state_q == INIT);
    assign core_next   = (state_q == NEXT);
    assign core_encdec = core_encdec_q;
    assign core_keylen = core_keylen_q;
    assign core_key    = core_key_q;
    assign core_block  = core_block_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_req_arbiter.sv
// ============================================================================
// Module  : tb_aes_req_arbiter
// Brief   : Scenario and randomized checks of aes_req_arbiter against a job-level model.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_aes_req_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req, req_encdec, req_keylen;
    logic [255:0] req_key0, req_key1;
    logic [127:0] req_block0, req_block1;
    logic         core_ready, core_result_valid;
    logic [127:0] core_result;
    logic         core_ready_nr, core_result_valid_nr;
    logic [127:0] core_result_nr;

    logic [1:0]   gnt, rsp_valid, gnt_nr, rsp_valid_nr;
    logic [127:0] rsp_data, core_block, rsp_data_nr, core_block_nr;
    logic         busy, core_init, core_next, core_encdec, core_keylen;
    logic         busy_nr, core_init_nr, core_next_nr, core_encdec_nr, core_keylen_nr;
    logic [255:0] core_key, core_key_nr;

    always #5 clk = ~clk;

    aes_req_arbiter #(.KEY_REUSE(1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_encdec(req_encdec), .req_keylen(req_keylen),
        .req_key0(req_key0), .req_key1(req_key1), .req_block0(req_block0), .req_block1(req_block1),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .core_init(core_init), .core_next(core_next), .core_encdec(core_encdec),
        .core_keylen(core_keylen), .core_key(core_key), .core_block(core_block),
        .core_ready(core_ready), .core_result_valid(core_result_valid), .core_result(core_result)
    );

    aes_req_arbiter #(.KEY_REUSE(0)) dut_nr (
        .clk(clk), .rst_n(rst_n), .req(req), .req_encdec(req_encdec), .req_keylen(req_keylen),
        .req_key0(req_key0), .req_key1(req_key1), .req_block0(req_block0), .req_block1(req_block1),
        .gnt(gnt_nr), .rsp_valid(rsp_valid_nr), .rsp_data(rsp_data_nr), .busy(busy_nr),
        .core_init(core_init_nr), .core_next(core_next_nr), .core_encdec(core_encdec_nr),
        .core_keylen(core_keylen_nr), .core_key(core_key_nr), .core_block(core_block_nr),
        .core_ready(core_ready_nr), .core_result_valid(core_result_valid_nr),
        .core_result(core_result_nr)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // AES core stand-ins: ready/valid are levels that drop on a start pulse and rise after a delay.
    int ready_delay = 3, result_delay = 2;
    int rdy_cnt = 0, res_cnt = 0, rdy_cnt_nr = 0, res_cnt_nr = 0;
    logic [127:0] last_result;

    always @(negedge clk) begin
        if (core_init) begin
            core_ready = 1'b0; rdy_cnt = ready_delay;
        end else if (rdy_cnt > 0) begin
            rdy_cnt--;
            if (rdy_cnt == 0) core_ready = 1'b1;
        end
        if (core_next) begin
            core_result_valid = 1'b0; res_cnt = result_delay;
        end else if (res_cnt > 0) begin
            res_cnt--;
            if (res_cnt == 0) begin
                core_result = {$urandom, $urandom, $urandom, $urandom};
                last_result = core_result;
                core_result_valid = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (core_init_nr) begin
            core_ready_nr = 1'b0; rdy_cnt_nr = ready_delay;
        end else if (rdy_cnt_nr > 0) begin
            rdy_cnt_nr--;
            if (rdy_cnt_nr == 0) core_ready_nr = 1'b1;
        end
        if (core_next_nr) begin
            core_result_valid_nr = 1'b0; res_cnt_nr = result_delay;
        end else if (res_cnt_nr > 0) begin
            res_cnt_nr--;
            if (res_cnt_nr == 0) begin
                core_result_nr = {$urandom, $urandom, $urandom, $urandom};
                core_result_valid_nr = 1'b1;
            end
        end
    end

    // Job-level reference model.
    bit           m_kv, m_last, m_keylen;
    logic [255:0] m_key;

    task automatic model_reset;
        m_kv = 1'b0; m_last = 1'b1; m_key = '0; m_keylen = 1'b0;
    endtask

    function automatic bit pick(input logic [1:0] r);
        if (r == 2'b11) return ~m_last;
        return r[1];
    endfunction

    function automatic bit is_hit(input logic [255:0] k, input logic kl);
        return m_kv && (k == m_key) && (kl == m_keylen);
    endfunction

    task automatic commit(input bit w, input logic [255:0] k, input logic kl, input bit hit);
        if (!hit) begin m_key = k; m_keylen = kl; m_kv = 1'b1; end
        m_last = w;
    endtask

    function automatic logic [1:0] oh(input bit w);
        return w ? 2'b10 : 2'b01;
    endfunction

    function automatic int max3(input int v);
        return (v > 3) ? v : 3;
    endfunction

    function automatic int exp_lat(input bit hit);
        return hit ? max3(result_delay + 1) : max3(ready_delay + 1) + max3(result_delay + 1);
    endfunction

    // Observations of one job, filled by run_job.
    logic [1:0]   j_g, j_rv;
    logic [127:0] j_data, j_cblk;
    logic [255:0] j_ck;
    logic         j_ckl, j_cenc;
    int           j_lat, j_inits, j_nexts, j_nx0, j_inits_nr, j_gcnt;
    bit           j_tmo;

    // Call at a negedge; drives req and records what the DUT does until rsp_valid.
    task automatic run_job(input logic [1:0] r, input bit hold);
        int t0;
        j_tmo = 1'b1; j_g = '0; j_rv = '0; j_data = '0; j_ck = '0; j_ckl = 1'b0;
        j_cenc = 1'b0; j_cblk = '0; j_lat = 0; j_inits = 0; j_nexts = 0; j_nx0 = 0;
        j_inits_nr = 0; j_gcnt = 0;
        req = r;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin j_tmo = 1'b0; break; end
        end
        if (j_tmo) begin req = 2'b00; return; end
        j_g = gnt; j_ck = core_key; j_ckl = core_keylen; j_cenc = core_encdec; j_cblk = core_block;
        t0 = cyc; j_inits = int'(core_init); j_nexts = int'(core_next); j_nx0 = j_nexts;
        j_inits_nr = int'(core_init_nr); j_gcnt = 1;
        if (!hold) req = 2'b00;
        j_tmo = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            j_inits += int'(core_init); j_nexts += int'(core_next);
            j_inits_nr += int'(core_init_nr); j_gcnt += int'(gnt != 2'b00);
            if (rsp_valid != 2'b00) begin j_tmo = 1'b0; break; end
        end
        j_rv = rsp_valid; j_data = rsp_data; j_lat = cyc - t0;
    endtask

    logic [255:0] K1, K2, K3;

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, rsp_valid, core_init, core_next, busy} !== 7'b0)
            $display("FAIL reset_ctrl: got %b, expected 0", {gnt, rsp_valid, core_init, core_next, busy});
        checks++;
        if ({rsp_data, core_key, core_block, core_encdec, core_keylen} !== '0) begin
            errors++; $display("FAIL reset_data: got nonzero data regs, expected 0");
        end
        checks++;
        if ({gnt_nr, rsp_valid_nr, busy_nr, rsp_data_nr, core_key_nr, core_block_nr,
             core_encdec_nr, core_keylen_nr} !== '0) begin
            errors++; $display("FAIL reset_nr: got nonzero outputs, expected 0");
        end
        if ({gnt, rsp_valid, core_init, core_next, busy} !== 7'b0) errors++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_cold_start;
        @(negedge clk);
        ready_delay = 5; result_delay = 2;
        req_key0 = K1; req_keylen = 2'b00; req_encdec = 2'b01; req_block0 = {4{32'h1234_5678}};
        run_job(2'b01, 1'b0);
        checks++; if (j_tmo) begin errors++; $display("FAIL cold_timeout: got timeout, expected response"); end
        checks++; if (j_g !== 2'b01) begin errors++; $display("FAIL cold_gnt: got %b, expected 01", j_g); end
        checks++; if (j_inits !== 1 || j_nexts !== 1) begin errors++;
            $display("FAIL cold_pulses: got init=%0d next=%0d, expected 1/1", j_inits, j_nexts); end
        checks++; if (j_rv !== 2'b01) begin errors++; $display("FAIL cold_rsp_valid: got %b, expected 01", j_rv); end
        checks++; if (j_data !== last_result) begin errors++;
            $display("FAIL cold_rsp_data: got %h, expected %h", j_data, last_result); end
        checks++; if (j_lat !== exp_lat(1'b0)) begin errors++;
            $display("FAIL cold_latency: got %0d, expected %0d", j_lat, exp_lat(1'b0)); end
        commit(1'b0, K1, 1'b0, 1'b0);
    endtask

    task automatic test_key_reuse;
        bit hit, tmo;
        tmo = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy_nr) begin tmo = 1'b0; break; end
        end
        checks++; if (tmo) begin errors++; $display("FAIL reuse_nr_idle: got busy, expected idle"); end
        result_delay = 3;
        hit = is_hit(K1, 1'b0);
        run_job(2'b01, 1'b0);
        checks++; if (j_inits !== int'(!hit)) begin errors++;
            $display("FAIL reuse_init: got %0d, expected %0d", j_inits, int'(!hit)); end
        checks++; if (j_nx0 !== 1) begin errors++; $display("FAIL reuse_next_at_capture: got %0d, expected 1", j_nx0); end
        checks++; if (j_lat !== exp_lat(hit)) begin errors++;
            $display("FAIL reuse_latency: got %0d, expected %0d", j_lat, exp_lat(hit)); end
        checks++; if (j_inits_nr !== 1) begin errors++;
            $display("FAIL noreuse_init: got %0d, expected 1", j_inits_nr); end
        checks++; if (j_data !== last_result || j_rv !== 2'b01) begin errors++;
            $display("FAIL reuse_rsp: got %b/%h, expected 01/%h", j_rv, j_data, last_result); end
        commit(1'b0, K1, 1'b0, hit);
        for (int i = 0; i < 200 && busy_nr; i++) @(negedge clk);
    endtask

    task automatic test_keylen_change;
        bit hit;
        @(negedge clk);
        req_key0 = K1;
        for (int n = 0; n < 2; n++) begin
            req_keylen = (n == 0) ? 2'b00 : 2'b01;
            hit = is_hit(K1, req_keylen[0]);
            run_job(2'b01, 1'b0);
            checks++; if (j_tmo || j_inits !== int'(!hit)) begin errors++;
                $display("FAIL keylen_init[%0d]: got %0d, expected %0d", n, j_inits, int'(!hit)); end
            commit(1'b0, K1, req_keylen[0], hit);
        end
    endtask

    task automatic test_tie;
        bit w, hit;
        logic [255:0] k;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        req_key0 = K1; req_key1 = K2; req_keylen = 2'b00;
        for (int n = 0; n < 4; n++) begin
            w = pick(2'b11);
            k = w ? K2 : K1;
            hit = is_hit(k, 1'b0);
            run_job(2'b11, 1'b1);
            checks++; if (j_tmo || j_g !== oh(w) || j_rv !== oh(w)) begin errors++;
                $display("FAIL tie_order[%0d]: got gnt=%b rsp=%b, expected %b", n, j_g, j_rv, oh(w)); end
            checks++; if (j_inits !== int'(!hit) || j_ck !== k) begin errors++;
                $display("FAIL tie_init[%0d]: got %0d, expected %0d", n, j_inits, int'(!hit)); end
            commit(w, k, 1'b0, hit);
        end
        req = 2'b00;
    endtask

    task automatic test_busy_ignore;
        bit tmo, early, hit;
        @(negedge clk);
        req_key0 = K2; req_key1 = K2; req_keylen = 2'b00; result_delay = 6; ready_delay = 2;
        req = 2'b01;
        tmo = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin tmo = 1'b0; break; end
        end
        req = 2'b00;
        checks++; if (tmo || gnt !== 2'b01) begin errors++; $display("FAIL busy_gnt0: got %b, expected 01", gnt); end
        for (int i = 0; i < 50 && !core_next; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        req = 2'b10;
        early = 1'b0; tmo = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) early = 1'b1;
            if (rsp_valid != 2'b00) begin tmo = 1'b0; break; end
        end
        checks++; if (tmo || early || rsp_valid !== 2'b01) begin errors++;
            $display("FAIL busy_ignore: got early=%0d rsp=%b, expected 0/01", early, rsp_valid); end
        hit = is_hit(K2, 1'b0);
        commit(1'b0, K2, 1'b0, hit);
        @(negedge clk);
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL busy_gnt1: got %b, expected 10", gnt); end
        req = 2'b00;
        tmo = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) begin tmo = 1'b0; break; end
        end
        checks++; if (tmo || rsp_valid !== 2'b10 || rsp_data !== last_result) begin errors++;
            $display("FAIL busy_rsp1: got %b, expected 10", rsp_valid); end
        hit = is_hit(K2, 1'b0);
        commit(1'b1, K2, 1'b0, hit);
    endtask

    task automatic test_reset_kwait;
        bit tmo;
        int stray;
        @(negedge clk);
        ready_delay = 20; result_delay = 2;
        req_key0 = K3; req_keylen = 2'b00;
        req = 2'b01;
        tmo = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin tmo = 1'b0; break; end
        end
        req = 2'b00;
        checks++; if (tmo) begin errors++; $display("FAIL rstk_gnt: got timeout, expected grant"); end
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, rsp_valid, core_init, core_next, busy} !== 7'b0 ||
            {rsp_data, core_key, core_block, core_encdec, core_keylen} !== '0) begin
            errors++; $display("FAIL rstk_outputs: got ctrl=%b, expected all zero",
                               {gnt, rsp_valid, core_init, core_next, busy});
        end
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        stray = 0;
        repeat (25) begin @(negedge clk); stray += int'(rsp_valid != 2'b00); end
        checks++; if (stray !== 0) begin errors++; $display("FAIL rstk_stray_rsp: got %0d, expected 0", stray); end
        ready_delay = 3;
        run_job(2'b01, 1'b0);
        checks++; if (j_tmo || j_inits !== 1 || j_rv !== 2'b01) begin errors++;
            $display("FAIL rstk_reinit: got init=%0d rsp=%b, expected 1/01", j_inits, j_rv); end
        commit(1'b0, K3, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        logic [1:0]   r;
        bit           w, hit;
        logic [255:0] k;
        logic [127:0] b;
        logic         kl, e;
        for (int n = 0; n < 12; n++) begin
            r = 2'($urandom_range(1, 3));
            req_key0 = ($urandom_range(0, 1) == 0) ? K1 : K2;
            req_key1 = ($urandom_range(0, 1) == 0) ? K1 : K2;
            req_keylen = 2'($urandom); req_encdec = 2'($urandom);
            req_block0 = {$urandom, $urandom, $urandom, $urandom};
            req_block1 = {$urandom, $urandom, $urandom, $urandom};
            ready_delay = int'($urandom_range(1, 6)); result_delay = int'($urandom_range(1, 6));
            w = pick(r);
            k = w ? req_key1 : req_key0; b = w ? req_block1 : req_block0;
            kl = req_keylen[w]; e = req_encdec[w];
            hit = is_hit(k, kl);
            run_job(r, 1'b0);
            checks++; if (j_tmo || j_g !== oh(w) || j_gcnt !== 1) begin errors++;
                $display("FAIL rnd_gnt[%0d]: got %b x%0d, expected %b x1", n, j_g, j_gcnt, oh(w)); end
            checks++; if (j_ck !== k || j_ckl !== kl || j_cenc !== e || j_cblk !== b) begin errors++;
                $display("FAIL rnd_payload[%0d]: got keylen=%b enc=%b, expected %b/%b", n, j_ckl, j_cenc, kl, e); end
            checks++; if (j_inits !== int'(!hit) || j_nexts !== 1) begin errors++;
                $display("FAIL rnd_pulses[%0d]: got init=%0d next=%0d, expected %0d/1", n, j_inits, j_nexts, int'(!hit)); end
            checks++; if (j_lat !== exp_lat(hit)) begin errors++;
                $display("FAIL rnd_latency[%0d]: got %0d, expected %0d", n, j_lat, exp_lat(hit)); end
            checks++; if (j_rv !== oh(w) || j_data !== last_result) begin errors++;
                $display("FAIL rnd_rsp[%0d]: got %b/%h, expected %b/%h", n, j_rv, j_data, oh(w), last_result); end
            commit(w, k, kl, hit);
        end
    endtask

    initial begin
        rst_n = 1'b1; req = '0; req_encdec = '0; req_keylen = '0;
        req_key0 = '0; req_key1 = '0; req_block0 = '0; req_block1 = '0;
        core_ready = 1'b1; core_result_valid = 1'b0; core_result = '0; last_result = '0;
        core_ready_nr = 1'b1; core_result_valid_nr = 1'b0; core_result_nr = '0;
        K1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        K2 = K1 ^ 256'h1;
        K3 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        model_reset();
        #3;
        test_reset();
        test_cold_start();
        test_key_reuse();
        test_keylen_change();
        test_tie();
        test_busy_ignore();
        test_reset_kwait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes_req_arbiter.md
AES_REQ_ARBITER -- requirements
Module: aes_req_arbiter

Interface
REQ-001 Parameter KEY_REUSE, default 1: when 1, key expansion is skipped if the key and keylen match the last expanded pair.
REQ-002 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-003 Port rst_n  input  1: asynchronous, active-low reset.
REQ-004 Port req  input  2: per-requester request; bit i belongs to requester i.
REQ-005 Port req_encdec  input  2: per-requester operation; 1 = encipher, 0 = decipher.
REQ-006 Port req_keylen  input  2: per-requester key length; 0 = AES128, 1 = AES256.
REQ-007 Port req_key0, req_key1  input  256 each: requester keys; AES128 uses bits [255:128].
REQ-008 Port req_block0, req_block1  input  128 each: requester input blocks.
REQ-009 Port gnt  output  2: one-cycle grant pulse; the payload has been captured.
REQ-010 Port rsp_valid  output  2: one-cycle result pulse to the job owner.
REQ-011 Port rsp_data  output  128: result of the last completed job; shared by both requesters.
REQ-012 Port busy  output  1: high whenever state is not IDLE.
REQ-013 Port core_init, core_next  output  1 each: one-cycle start pulses to the AES core.
REQ-014 Port core_encdec  output  1, core_keylen  output  1, core_key  output  256, core_block  output  128: registered job fields, stable for the whole job.
REQ-015 Port core_ready  input  1: key memory ready from the core.
REQ-016 Port core_result_valid  input  1, core_result  input  128: core result handshake.

Function
REQ-017 States SHALL be IDLE, INIT, KBLANK, KWAIT, NEXT, RBLANK, RWAIT.
REQ-018 IDLE: when any req bit is sampled high, the arbiter SHALL capture the winner's payload into the core_* registers and latch the owner at that edge.
- gnt[owner] is high during the following cycle only.
REQ-019 Arbitration SHALL be round-robin on last_owner.
- A single request always wins.
- When both requests are high, the requester other than last_owner wins.
- last_owner resets to 1, so requester 0 wins the first tie.
REQ-020 From IDLE, the next state SHALL be NEXT on a key hit, otherwise INIT.
- Key hit = KEY_REUSE=1, key_valid=1, captured key equals stored key, and captured keylen equals stored keylen.
- All 256 key bits are compared regardless of keylen.
REQ-021 INIT SHALL assert core_init for exactly one cycle, then go to KBLANK.
- KBLANK lasts one cycle and ignores core_ready, then goes to KWAIT.
REQ-022 KWAIT SHALL hold until core_ready=1 is sampled.
- At that edge: store key and keylen, set key_valid=1, go to NEXT.
REQ-023 NEXT SHALL assert core_next for exactly one cycle, then go to RBLANK.
- RBLANK lasts one cycle and ignores core_result_valid, then goes to RWAIT.
REQ-024 RWAIT: at the edge where core_result_valid=1 is sampled, the arbiter SHALL do all of the following.
- Register rsp_data <= core_result.
- Pulse rsp_valid[owner] for the following cycle.
- Set last_owner <= owner.
- Return to IDLE.
REQ-025 Requests arriving while busy SHALL be ignored until IDLE; the arbiter never preempts a job.
REQ-026 A requester SHALL drop req in the cycle after gnt; a req still high in IDLE is a new job.
- The earliest new grant edge is the edge after rsp_valid rises.
REQ-027 rsp_data SHALL hold its value until the next completed job.
- rsp_valid and gnt are never both high for the same requester in the same cycle.
REQ-028 With the state register unchanged, job latency from the grant edge to the rsp_valid rise SHALL be:
- key hit: 3 + (RWAIT cycles) cycles;
- key miss: 3 + (KWAIT cycles) + 3 + (RWAIT cycles) cycles.

Reset
REQ-029 On rst_n low, the arbiter SHALL asynchronously set the following, regardless of state, including mid-job:
- state=IDLE;
- gnt=0, rsp_valid=0, core_init=0, core_next=0, busy=0;
- rsp_data=0, core_key=0, core_block=0, core_encdec=0, core_keylen=0;
- key_valid=0, last_owner=1.
REQ-030 After reset release, the first job SHALL always run INIT.
- An interrupted job produces no rsp_valid.

Verification
REQ-031 Cold start: req=01, key0=K1, keylen=0, core_ready 5 cycles after init -> gnt=01, one core_init pulse, one core_next pulse, then rsp_valid=01 with rsp_data=core_result.
REQ-032 Key reuse: second req=01 with the same K1 -> no core_init, core_next the cycle after capture. Repeat with KEY_REUSE=0 -> core_init issued.
REQ-033 Tie: req=11 held from reset -> order 0,1,0,1 across four jobs; keys K1/K2 differ -> every job runs INIT.
REQ-034 Keylen change: same key with keylen 0 then 1 -> the second job runs INIT.
REQ-035 Busy ignore: req=10 asserted during RWAIT of job 0 -> no gnt until IDLE, then gnt=10.
REQ-036 Reset during KWAIT -> all outputs 0 immediately; the next job with the same key runs INIT.
